// File: rtl/fir_pkg.sv
// Shared state encoding, default geometry and sizing helpers for the FIR
// front-end sequencer.
package fir_pkg;

  localparam int DEF_X_N_SIZE     = 6;
  localparam int DEF_TAP_SIZE     = 2;
  localparam int DEF_NBR_OF_TAPS  = 8;
  localparam int DEF_SETUP_CYCLES = 4;
  localparam int DEF_IDLE_TIMEOUT = 8;

  typedef enum logic [2:0] {
    WAIT_SETUP = 3'd0,
    IDLE       = 3'd1,
    STREAM     = 3'd2,
    CONFIG     = 3'd3,
    GAP        = 3'd4
  } seq_state_t;

  // Words needed to carry every tap, rounding a partial last word up.
  function automatic int cfg_words_calc(input int taps, input int tap_size, input int word_size);
    return (taps * tap_size + word_size - 1) / word_size;
  endfunction

  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_CFG_WORDS = cfg_words_calc(DEF_NBR_OF_TAPS, DEF_TAP_SIZE, DEF_X_N_SIZE);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag;
// it holds at MAX so a long-held enable can never wrap it.
module sat_counter
  import fir_pkg::*;
#(
  parameter int MAX   = 1,
  parameter int WIDTH = ctr_width(MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == WIDTH'(MAX));

  // Count register: clear wins over enable, increment stops at MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {WIDTH{1'b0}};
    end else if (clr) begin
      count <= {WIDTH{1'b0}};
    end else if (en && !tc) begin
      count <= count + WIDTH'(1'b1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Front-end sequencer for the FIR datapath: turns a mode-tagged word stream
// into FIR-legal x_n / tvalid / set_coeffs sequencing with registered outputs.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int X_N_SIZE     = DEF_X_N_SIZE,
  parameter int TAP_SIZE     = DEF_TAP_SIZE,
  parameter int NBR_OF_TAPS  = DEF_NBR_OF_TAPS,
  parameter int CFG_WORDS    = cfg_words_calc(NBR_OF_TAPS, TAP_SIZE, X_N_SIZE),
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_mode,
  input  logic [X_N_SIZE-1:0] in_data,
  output logic                in_ready,
  output logic [X_N_SIZE-1:0] fir_x_n,
  output logic                fir_tvalid,
  output logic                fir_set_coeffs,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                busy
);

  localparam int SETUP_W = ctr_width(SETUP_CYCLES - 1);
  localparam int IDLE_W  = ctr_width(IDLE_TIMEOUT);
  localparam int WORD_W  = ctr_width(CFG_WORDS);

  seq_state_t          state_r;
  seq_state_t          next_state_s;
  logic [X_N_SIZE-1:0] stash_r;
  logic [X_N_SIZE-1:0] x_n_s;
  logic                tvalid_s;
  logic                set_coeffs_s;
  logic                done_s;
  logic                err_s;
  logic                ready_s;
  logic                stash_ld_s;
  logic                word_en_s;
  logic                in_fire_s;
  logic                setup_tc_s;
  logic                idle_tc_s;
  logic                word_tc_s;
  logic [SETUP_W-1:0]  setup_count_unused_s;
  logic [IDLE_W-1:0]   idle_count_unused_s;
  logic [WORD_W-1:0]   word_count_s;

  assign in_fire_s = in_valid && in_ready;

  // Setup counter: the last of SETUP_CYCLES edges is the one that sees tc.
  sat_counter #(.MAX(SETUP_CYCLES - 1), .WIDTH(SETUP_W)) u_setup_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r != WAIT_SETUP),
    .en    (state_r == WAIT_SETUP),
    .count (setup_count_unused_s),
    .tc    (setup_tc_s)
  );

  sat_counter #(.MAX(IDLE_TIMEOUT), .WIDTH(IDLE_W)) u_idle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((next_state_s != STREAM) || in_fire_s),
    .en    ((state_r == STREAM) && !in_fire_s),
    .count (idle_count_unused_s),
    .tc    (idle_tc_s)
  );

  sat_counter #(.MAX(CFG_WORDS), .WIDTH(WORD_W)) u_word_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (next_state_s != CONFIG),
    .en    (word_en_s),
    .count (word_count_s),
    .tc    (word_tc_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= WAIT_SETUP;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and next-output decode; every path leaves both FIR controls
  // low for a cycle before the other one may rise.
  always_comb begin
    next_state_s = state_r;
    x_n_s        = {X_N_SIZE{1'b0}};
    tvalid_s     = 1'b0;
    set_coeffs_s = 1'b0;
    done_s       = 1'b0;
    err_s        = 1'b0;
    stash_ld_s   = 1'b0;
    word_en_s    = 1'b0;
    case (state_r)
      WAIT_SETUP: begin
        if (setup_tc_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_SETUP;
        end
      end
      IDLE: begin
        if (in_fire_s && in_mode) begin
          next_state_s = CONFIG;
          x_n_s        = in_data;
          set_coeffs_s = 1'b1;
          word_en_s    = 1'b1;
        end else if (in_fire_s) begin
          next_state_s = STREAM;
          x_n_s        = in_data;
          tvalid_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      STREAM: begin
        if (in_fire_s && in_mode) begin
          next_state_s = GAP;
          stash_ld_s   = 1'b1;
        end else if (in_fire_s) begin
          next_state_s = STREAM;
          x_n_s        = in_data;
          tvalid_s     = 1'b1;
        end else if (idle_tc_s) begin
          next_state_s = IDLE;
        end else begin
          // Zero-stuff: tvalid must stay high or the FIR flushes its delay line.
          next_state_s = STREAM;
          tvalid_s     = 1'b1;
        end
      end
      GAP: begin
        next_state_s = CONFIG;
        x_n_s        = stash_r;
        set_coeffs_s = 1'b1;
        word_en_s    = 1'b1;
      end
      CONFIG: begin
        if (word_tc_s) begin
          next_state_s = IDLE;
          done_s       = 1'b1;
        end else if (in_fire_s && in_mode) begin
          next_state_s = CONFIG;
          x_n_s        = in_data;
          set_coeffs_s = 1'b1;
          word_en_s    = 1'b1;
        end else if (in_fire_s) begin
          next_state_s = IDLE;
          err_s        = 1'b1;
        end else begin
          next_state_s = CONFIG;
        end
      end
      default: begin
        next_state_s = WAIT_SETUP;
      end
    endcase
  end

  // Ready decode; CONFIG stops accepting once the final word has gone out.
  always_comb begin
    ready_s = 1'b0;
    case (next_state_s)
      IDLE, STREAM: begin
        ready_s = 1'b1;
      end
      CONFIG: begin
        if (word_en_s && (word_count_s == WORD_W'(CFG_WORDS - 1))) begin
          ready_s = 1'b0;
        end else begin
          ready_s = 1'b1;
        end
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Holds the config word that arrived mid-stream across the GAP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stash_r <= {X_N_SIZE{1'b0}};
    end else if (stash_ld_s) begin
      stash_r <= in_data;
    end else begin
      stash_r <= stash_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready       <= 1'b0;
      fir_x_n        <= {X_N_SIZE{1'b0}};
      fir_tvalid     <= 1'b0;
      fir_set_coeffs <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_err        <= 1'b0;
      busy           <= 1'b1;
    end else begin
      in_ready       <= ready_s;
      fir_x_n        <= x_n_s;
      fir_tvalid     <= tvalid_s;
      fir_set_coeffs <= set_coeffs_s;
      cfg_done       <= done_s;
      cfg_err        <= err_s;
      busy           <= (next_state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: directed vector table, hand-written corner sequences
// and randomized traffic checked against a cycle-level behavioural model.
module tb_fir_seq_ctrl;

  localparam int CFGW  = 3;
  localparam int SETUP = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_mode;
  logic [5:0] in_data;
  logic       in_ready;
  logic [5:0] fir_x_n;
  logic       fir_tvalid;
  logic       fir_set_coeffs;
  logic       cfg_done;
  logic       cfg_err;
  logic       busy;

  fir_seq_ctrl #(
    .X_N_SIZE(6), .TAP_SIZE(2), .NBR_OF_TAPS(8), .CFG_WORDS(3),
    .SETUP_CYCLES(4), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
    .in_data(in_data), .in_ready(in_ready), .fir_x_n(fir_x_n),
    .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_setup_left;
  bit         m_stream;
  bit         m_load;
  bit         m_done_pend;
  int         m_run;
  int         m_words;
  logic [5:0] m_gap_q[$];
  logic [5:0] e_x;
  bit         e_tv, e_sc, e_dn, e_er, e_busy, e_rdy;

  function automatic bit m_ready();
    return (m_setup_left == 0) && (m_gap_q.size() == 0) && !m_done_pend;
  endfunction

  task automatic model_edge(input bit rst, input bit v, input bit md, input logic [5:0] d);
    bit fire;
    fire = v && m_ready();
    e_x = 6'd0; e_tv = 1'b0; e_sc = 1'b0; e_dn = 1'b0; e_er = 1'b0;
    if (rst) begin
      m_setup_left = SETUP; m_stream = 1'b0; m_load = 1'b0; m_done_pend = 1'b0;
      m_run = 0; m_words = 0; m_gap_q.delete();
    end else if (m_setup_left > 0) begin
      m_setup_left--;
    end else if (m_gap_q.size() > 0) begin
      e_x = m_gap_q.pop_front(); e_sc = 1'b1; m_load = 1'b1; m_words = 1;
      if (m_words == CFGW) m_done_pend = 1'b1;
    end else if (m_done_pend) begin
      e_dn = 1'b1; m_done_pend = 1'b0; m_load = 1'b0; m_words = 0;
    end else if (m_load) begin
      if (fire && md) begin
        e_x = d; e_sc = 1'b1; m_words++;
        if (m_words == CFGW) m_done_pend = 1'b1;
      end else if (fire) begin
        e_er = 1'b1; m_load = 1'b0; m_words = 0;
      end
    end else if (m_stream) begin
      if (fire && md) begin
        m_gap_q.push_back(d); m_stream = 1'b0; m_run = 0;
      end else if (fire) begin
        e_x = d; e_tv = 1'b1; m_run = 0;
      end else if (m_run == TMO) begin
        m_stream = 1'b0; m_run = 0;
      end else begin
        m_run++; e_tv = 1'b1;
      end
    end else if (fire) begin
      e_x = d;
      if (md) begin
        e_sc = 1'b1; m_load = 1'b1; m_words = 1;
        if (m_words == CFGW) m_done_pend = 1'b1;
      end else begin
        e_tv = 1'b1; m_stream = 1'b1; m_run = 0;
      end
    end
    e_rdy  = m_ready();
    e_busy = (m_setup_left > 0) || m_stream || m_load || (m_gap_q.size() > 0) || m_done_pend;
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input bit rst, input bit v, input bit md, input logic [5:0] d);
    reset = rst; in_valid = v; in_mode = md; in_data = d;
    @(posedge clk);
    #1;
    model_edge(rst, v, md, d);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_x_n"},   fir_x_n,        e_x);
    chk({tag, "_tvalid"}, fir_tvalid,    e_tv);
    chk({tag, "_setc"},  fir_set_coeffs, e_sc);
    chk({tag, "_done"},  cfg_done,       e_dn);
    chk({tag, "_err"},   cfg_err,        e_er);
    chk({tag, "_busy"},  busy,           e_busy);
    chk({tag, "_ready"}, in_ready,       e_rdy);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst, v, md;
    logic [5:0] d;
    logic [5:0] x;
    bit         tv, sc, dn, er, bz, rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit v, input bit md, input logic [5:0] d,
                     input logic [5:0] x, input bit tv, input bit sc, input bit dn,
                     input bit er, input bit bz, input bit rd);
    vec_t t;
    t = '{rst, v, md, d, x, tv, sc, dn, er, bz, rd};
    tbl.push_back(t);
  endtask

  int v_pct, m_pct;
  bit prev_tv, prev_sc;
  bit r_rst, r_v, r_md;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = 6'd0;

    // reset, then setup wait with input offered but not accepted
    add(1, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 6'h09, 6'h00, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 6'h09, 6'h00, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1);
    // stream 5, -3, 7, eight zero-stuffed cycles, then timeout
    add(0, 1, 0, 6'h05, 6'h05, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 6'h3D, 6'h3D, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 6'h07, 6'h07, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < TMO; i++) add(0, 0, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1);
    // full config load; the word offered on the done cycle is not taken
    add(0, 1, 1, 6'h15, 6'h15, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 6'h2A, 6'h2A, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 6'h3F, 6'h3F, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 6'h01, 6'h00, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1);
    // aborted load, then a fresh load
    add(0, 1, 1, 6'h01, 6'h01, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 6'h02, 6'h02, 0, 1, 0, 0, 1, 1);
    add(0, 1, 0, 6'h04, 6'h00, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 6'h0A, 6'h0A, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 6'h0B, 6'h0B, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 6'h0C, 6'h0C, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 6'h00, 6'h00, 0, 0, 1, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].md, tbl[i].d);
      chk($sformatf("vec%0d_x_n", i),    fir_x_n,        tbl[i].x);
      chk($sformatf("vec%0d_tvalid", i), fir_tvalid,     tbl[i].tv);
      chk($sformatf("vec%0d_setc", i),   fir_set_coeffs, tbl[i].sc);
      chk($sformatf("vec%0d_done", i),   cfg_done,       tbl[i].dn);
      chk($sformatf("vec%0d_err", i),    cfg_err,        tbl[i].er);
      chk($sformatf("vec%0d_busy", i),   busy,           tbl[i].bz);
      chk($sformatf("vec%0d_ready", i),  in_ready,       tbl[i].rd);
    end

    // stream-to-config switchover through the gap cycle
    step(0, 1, 0, 6'h05);
    chk("s2c_stream_tvalid", fir_tvalid, 1'b1);
    step(0, 1, 1, 6'h11);
    chk("s2c_gap_tvalid", fir_tvalid, 1'b0);
    chk("s2c_gap_setc", fir_set_coeffs, 1'b0);
    chk("s2c_gap_ready", in_ready, 1'b0);
    check_model("s2c_gap");
    step(0, 1, 1, 6'h22);
    chk("s2c_cfg1_setc", fir_set_coeffs, 1'b1);
    chk("s2c_cfg1_x_n", fir_x_n, 6'h11);
    check_model("s2c_cfg1");
    step(0, 1, 1, 6'h12);
    chk("s2c_cfg2_x_n", fir_x_n, 6'h12);
    step(0, 1, 1, 6'h13);
    check_model("s2c_cfg3");
    step(0, 0, 0, 6'h00);
    chk("s2c_done", cfg_done, 1'b1);
    check_model("s2c_end");

    // reset in the middle of a load
    step(0, 1, 1, 6'h21);
    step(0, 1, 1, 6'h22);
    step(1, 1, 1, 6'h23);
    chk("rst_mid_setc", fir_set_coeffs, 1'b0);
    chk("rst_mid_x_n", fir_x_n, 6'h00);
    chk("rst_mid_busy", busy, 1'b1);
    chk("rst_mid_ready", in_ready, 1'b0);
    chk("rst_mid_done", cfg_done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 6'h00);
      chk($sformatf("rst_post%0d_done", i), cfg_done, 1'b0);
      check_model($sformatf("rst_post%0d", i));
    end

    // randomized traffic with shifting bias
    prev_tv = fir_tvalid;
    prev_sc = fir_set_coeffs;
    v_pct = 60; m_pct = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: v_pct = 20;
          1: v_pct = 60;
          default: v_pct = 97;
        endcase
        case ($urandom_range(0, 2))
          0: m_pct = 10;
          1: m_pct = 50;
          default: m_pct = 90;
        endcase
      end
      r_rst = ($urandom_range(0, 399) == 0);
      r_v   = ($urandom_range(0, 99) < v_pct);
      r_md  = ($urandom_range(0, 99) < m_pct);
      step(r_rst, r_v, r_md, 6'($urandom_range(0, 63)));
      check_model($sformatf("rnd%0d", c));
      chk($sformatf("rnd%0d_excl", c), fir_tvalid & fir_set_coeffs, 1'b0);
      chk($sformatf("rnd%0d_switch", c),
          (prev_tv & fir_set_coeffs) | (prev_sc & fir_tvalid), 1'b0);
      prev_tv = fir_tvalid;
      prev_sc = fir_set_coeffs;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
